mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 64-bit memory port between three L1 data-cache requesters:
//   - dirty-line writeback (WB)
//   - demand miss refill (RF)
//   - next-block prefetch (PF)
//  Sits between the 2-way L1 data cache and the memory model. Serialises one
//  block transaction at a time over a req/ack handshake with variable latency.
// PARAMETERS
//  ADDR_W     32   width of all address ports
//  BLOCK_W    64   block/data width (equals memory bus width)
//  OFFSET_LEN 3    low address bits forced to 0 on mem_addr (block aligned)
//  PF_STARVE  15   PF wait-cycle limit before PF outranks RF (4-bit counter)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous reset, active-low
//  wb_req     in   1        WB request; held until wb_done
//  wb_addr    in   ADDR_W   WB block address
//  wb_data    in   BLOCK_W  WB block data
//  wb_gnt     out  1        1-cycle pulse: WB accepted
//  wb_done    out  1        1-cycle pulse: WB write acked by memory
//  rf_req     in   1        RF request; held until rf_done
//  rf_addr    in   ADDR_W   RF block address
//  rf_gnt     out  1        1-cycle pulse: RF accepted
//  rf_done    out  1        1-cycle pulse: rsp_data valid for RF
//  pf_req     in   1        PF request; may drop any time before pf_gnt
//  pf_addr    in   ADDR_W   PF block address
//  pf_gnt     out  1        1-cycle pulse: PF accepted
//  pf_done    out  1        1-cycle pulse: rsp_data valid for PF
//  rsp_data   out  BLOCK_W  read data, registered from mem_rdata
//  mem_req    out  1        memory request, held until mem_ack
//  mem_we     out  1        1 = write (WB), 0 = read (RF/PF)
//  mem_addr   out  ADDR_W   {addr[ADDR_W-1:OFFSET_LEN], OFFSET_LEN'b0}
//  mem_wdata  out  BLOCK_W  latched wb_data
//  mem_ack    in   1        memory completion; mem_rdata valid same cycle
//  mem_rdata  in   BLOCK_W  memory read data
//  busy       out  1        1 in any state other than IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; all outputs 0; starve counter 0.
//    Any in-flight transaction is dropped; no done pulse is issued for it.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE:
//    IDLE:  if any req, choose a winner; pulse its gnt; latch addr/data/ID;
//           go to ISSUE next cycle.
//    ISSUE: mem_req=1 with stable mem_addr/mem_we/mem_wdata until mem_ack.
//           On mem_ack: capture mem_rdata into rsp_data; go to RESP.
//    RESP:  pulse the winner's done (1 cycle); rsp_data holds until the next
//           RESP; return to IDLE.
//  - Minimum transaction is 3 cycles (ack in the first ISSUE cycle).
//    No new grant is issued in RESP.
//  - Priority (base): WB > RF > PF. WB precedes RF so an evicted dirty line
//    reaches memory before the same set is refilled.
//  - Starvation: 4-bit counter increments each IDLE cycle with pf_req=1 and
//    no PF grant; saturates. At PF_STARVE, PF outranks RF (never WB).
//    Clears on pf_gnt or when pf_req=0.
//  - Same-block squash: in IDLE, if pf_req and rf_req target the same block
//    (addr[ADDR_W-1:OFFSET_LEN] equal), PF is not granted; RF is served.
//  - Deasserting req after gnt does not abort; done still pulses.
//  - mem_ack outside ISSUE is ignored.
//  - At most one gnt and one done asserted per cycle.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: RF and PF alternate via a 1-bit last-winner flag
//    (flag toggles only on an RF or PF grant). WB stays highest priority.
//    Starvation counter removed; PF_STARVE unused.
//  MEM_ARB_RR_EN undefined: fixed priority plus starvation promotion, as above.
// TESTING
//  - Reset: rst_n low mid-ISSUE -> next edge: mem_req=0, busy=0, no done
//    pulses.
//  - Simultaneous req: wb/rf/pf_req=1 together -> grant order WB, RF, PF.
//    mem_we=1 for the first transaction only.
//  - Latency: rf_addr=0x0000_1234, mem_ack on the 4th ISSUE cycle ->
//    mem_addr=0x0000_1230; rf_done 1 cycle after ack;
//    rsp_data=mem_rdata=64'hDEAD_BEEF_0123_4567.
//  - Starvation: rf_req held high with pf_req high (no MEM_ARB_RR_EN) ->
//    pf_gnt after 15 IDLE wait cycles. With MEM_ARB_RR_EN, RF/PF grants
//    alternate.
//  - Squash: rf_addr=0x40, pf_addr=0x44 together -> only rf_gnt; with
//    pf_addr=0x48 instead, PF granted after RF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Serialises WB / RF / PF block transactions onto one memory req/ack port.
// Build option MEM_ARB_RR_EN: RF/PF round-robin instead of PF starvation promotion.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int BLOCK_W    = 64,
  parameter int OFFSET_LEN = 3,
  parameter int PF_STARVE  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_req,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [BLOCK_W-1:0] wb_data,
  output logic               wb_gnt,
  output logic               wb_done,
  input  logic               rf_req,
  input  logic [ADDR_W-1:0]  rf_addr,
  output logic               rf_gnt,
  output logic               rf_done,
  input  logic               pf_req,
  input  logic [ADDR_W-1:0]  pf_addr,
  output logic               pf_gnt,
  output logic               pf_done,
  output logic [BLOCK_W-1:0] rsp_data,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic               mem_ack,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {ID_NONE = 2'd0, ID_WB = 2'd1, ID_RF = 2'd2, ID_PF = 2'd3} id_t;

  localparam logic [ADDR_W-1:0] BLK_MASK = {{(ADDR_W-OFFSET_LEN){1'b1}}, {OFFSET_LEN{1'b0}}};

  state_t              r_state, w_next;
  id_t                 r_id, w_win;
  logic                w_squash, w_pf_ok, w_grant, w_ack;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                r_wb_gnt, r_rf_gnt, r_pf_gnt;
  logic                r_wb_done, r_rf_done, r_pf_done;
  logic                r_mem_req, r_mem_we, r_busy;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [BLOCK_W-1:0]  r_mem_wdata, r_rsp_data;
`ifdef MEM_ARB_RR_EN
  logic                r_last_pf;
`else
  localparam logic [3:0] STARVE_LIM = 4'(PF_STARVE);
  logic [3:0]          r_starve;
`endif

  // Winner selection; a prefetch to the block being refilled is redundant and never wins.
  always_comb begin
    w_squash = pf_req && rf_req && (((rf_addr ^ pf_addr) & BLK_MASK) == {ADDR_W{1'b0}});
    w_pf_ok  = pf_req && !w_squash;
    w_win    = ID_NONE;
    if (wb_req) begin
      w_win = ID_WB;
    end else if (rf_req && w_pf_ok) begin
`ifdef MEM_ARB_RR_EN
      if (r_last_pf) w_win = ID_RF;
      else           w_win = ID_PF;
`else
      if (r_starve >= STARVE_LIM) w_win = ID_PF;
      else                        w_win = ID_RF;
`endif
    end else if (rf_req) begin
      w_win = ID_RF;
    end else if (w_pf_ok) begin
      w_win = ID_PF;
    end else begin
      w_win = ID_NONE;
    end
  end

  // Address of the selected requester.
  always_comb begin
    w_sel_addr = {ADDR_W{1'b0}};
    case (w_win)
      ID_WB:   w_sel_addr = wb_addr;
      ID_RF:   w_sel_addr = rf_addr;
      ID_PF:   w_sel_addr = pf_addr;
      default: w_sel_addr = {ADDR_W{1'b0}};
    endcase
  end

  // Next-state logic: grants only from IDLE, acks only honoured in ISSUE.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win != ID_NONE) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          w_ack  = 1'b1;
          w_next = S_RESP;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, handshake pulses and latched transaction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_id        <= ID_NONE;
      r_busy      <= 1'b0;
      r_wb_gnt    <= 1'b0;
      r_rf_gnt    <= 1'b0;
      r_pf_gnt    <= 1'b0;
      r_wb_done   <= 1'b0;
      r_rf_done   <= 1'b0;
      r_pf_done   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {BLOCK_W{1'b0}};
      r_rsp_data  <= {BLOCK_W{1'b0}};
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != S_IDLE);
      r_wb_gnt  <= w_grant && (w_win == ID_WB);
      r_rf_gnt  <= w_grant && (w_win == ID_RF);
      r_pf_gnt  <= w_grant && (w_win == ID_PF);
      r_wb_done <= w_ack && (r_id == ID_WB);
      r_rf_done <= w_ack && (r_id == ID_RF);
      r_pf_done <= w_ack && (r_id == ID_PF);
      if (w_grant) begin
        r_id       <= w_win;
        r_mem_req  <= 1'b1;
        r_mem_we   <= (w_win == ID_WB);
        r_mem_addr <= w_sel_addr & BLK_MASK;
        if (w_win == ID_WB) r_mem_wdata <= wb_data;
      end else if (w_ack) begin
        r_mem_req  <= 1'b0;
        r_rsp_data <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last RF/PF winner; resets to "PF" so RF is preferred first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_pf <= 1'b1;
    end else if (w_grant && ((w_win == ID_RF) || (w_win == ID_PF))) begin
      r_last_pf <= (w_win == ID_PF);
    end
  end
`else
  // Saturating count of IDLE cycles in which a pending PF lost arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (!pf_req || (w_grant && (w_win == ID_PF))) begin
      r_starve <= 4'd0;
    end else if ((r_state == S_IDLE) && (r_starve != 4'hF)) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`endif

  assign wb_gnt    = r_wb_gnt;
  assign rf_gnt    = r_rf_gnt;
  assign pf_gnt    = r_pf_gnt;
  assign wb_done   = r_wb_done;
  assign rf_done   = r_rf_done;
  assign pf_done   = r_pf_done;
  assign rsp_data  = r_rsp_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transactions queued at stimulus time,
// checked at grant and popped at done; includes a variable-latency memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_req = 1'b0, rf_req = 1'b0, pf_req = 1'b0;
  logic [31:0] wb_addr = 32'd0, rf_addr = 32'd0, pf_addr = 32'd0;
  logic [63:0] wb_data = 64'd0;
  logic        wb_gnt, wb_done, rf_gnt, rf_done, pf_gnt, pf_done;
  logic [63:0] rsp_data, mem_wdata;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt), .wb_done(wb_done),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_gnt(rf_gnt), .rf_done(rf_done),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_gnt(pf_gnt), .pf_done(pf_done),
    .rsp_data(rsp_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;    // 0 WB, 1 RF, 2 PF
    logic [31:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0, n_err = 0;
  int   lat = 1, iss_cnt = 0, rf_left = 0, pf_left = 0;
  bit   ack_driven = 1'b0, pf_drop_on_rf = 1'b0;
  logic [63:0] saved_rsp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_1230) return 64'hDEAD_BEEF_0123_4567;
    return {~a, a};
  endfunction

  function automatic logic [2:0] id_vec(input logic [1:0] id);
    case (id)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] id, input logic [31:0] raw, input logic we,
                          input logic [63:0] wd);
    exp_t e;
    e.id    = id;
    e.addr  = raw & 32'hFFFF_FFF8;
    e.we    = we;
    e.wdata = wd;
    e.rdata = mem_model(raw & 32'hFFFF_FFF8);
    sb_q.push_back(e);
  endtask

  // One clock: check outputs at the falling edge, then update requesters and memory.
  task automatic step();
    logic [2:0] g, d;
    exp_t e;
    @(negedge clk);
    g = {wb_gnt, rf_gnt, pf_gnt};
    d = {wb_done, rf_done, pf_done};
    if (ack_driven) begin
      check_eq("done_after_ack", 64'(d != 3'b000), 64'd1);
      ack_driven = 1'b0;
    end
    if (g != 3'b000) begin
      if (sb_q.size() == 0) check_eq("gnt_unexpected", 64'(g), 64'd0);
      else begin
        e = sb_q[0];
        check_eq("gnt_id", 64'(g), 64'(id_vec(e.id)));
        check_eq("mem_req_at_gnt", 64'(mem_req), 64'd1);
        check_eq("busy_at_gnt", 64'(busy), 64'd1);
        check_eq("mem_addr", 64'(mem_addr), 64'(e.addr));
        check_eq("mem_we", 64'(mem_we), 64'(e.we));
        if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
      end
    end
    if (d != 3'b000) begin
      if (sb_q.size() == 0) check_eq("done_unexpected", 64'(d), 64'd0);
      else begin
        e = sb_q.pop_front();
        check_eq("done_id", 64'(d), 64'(id_vec(e.id)));
        if (!e.we) check_eq("rsp_data", rsp_data, e.rdata);
      end
    end
    if (wb_done) wb_req = 1'b0;
    if (rf_done) begin
      if (pf_drop_on_rf) begin
        pf_req = 1'b0;
        pf_drop_on_rf = 1'b0;
      end
      if (rf_left > 0) rf_left--;
      if (rf_left == 0) rf_req = 1'b0;
    end
    if (pf_gnt) begin
      if (pf_left > 0) pf_left--;
      if (pf_left == 0) pf_req = 1'b0;
    end
    if (mem_req && !mem_ack) begin
      iss_cnt++;
      if (iss_cnt >= lat) begin
        mem_ack    = 1'b1;
        mem_rdata  = mem_model(mem_addr);
        ack_driven = 1'b1;
      end else begin
        mem_rdata = {$urandom, $urandom};
      end
    end else begin
      mem_ack   = 1'b0;
      iss_cnt   = 0;
      mem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (((sb_q.size() != 0) || busy) && (n < budget)) begin
      step();
      n++;
    end
    check_eq("drained", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    step();
    step();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", 64'({wb_gnt, wb_done, rf_gnt, rf_done, pf_gnt, pf_done, mem_req, mem_we, busy}), 64'd0);
    check_eq("rst_rsp", rsp_data, 64'd0);
    check_eq("rst_addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    step();

    // Simultaneous requests: WB, then RF, then PF.
    lat = 2;
    wb_addr = 32'h0000_0085; wb_data = 64'h1111_2222_3333_4444;
    rf_addr = 32'h0000_1000; pf_addr = 32'h0000_2000;
    push_exp(2'd0, wb_addr, 1'b1, wb_data);
    push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    push_exp(2'd2, pf_addr, 1'b0, 64'd0);
    wb_req = 1'b1; rf_req = 1'b1; rf_left = 1; pf_req = 1'b1; pf_left = 1;
    run_until_idle(100);

    // Refill with ack on the 4th ISSUE cycle.
    lat = 4;
    rf_addr = 32'h0000_1234;
    push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    rf_req = 1'b1; rf_left = 1;
    run_until_idle(100);
    check_eq("lat_rsp_value", rsp_data, 64'hDEAD_BEEF_0123_4567);

    // Same block: prefetch squashed and then withdrawn.
    lat = 1;
    rf_addr = 32'h0000_0040; pf_addr = 32'h0000_0044;
    push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    rf_req = 1'b1; rf_left = 1; pf_req = 1'b1; pf_left = 1; pf_drop_on_rf = 1'b1;
    run_until_idle(100);

    // Adjacent block: both served.
    pf_addr = 32'h0000_0048;
`ifdef MEM_ARB_RR_EN
    push_exp(2'd2, pf_addr, 1'b0, 64'd0);
    push_exp(2'd1, rf_addr, 1'b0, 64'd0);
`else
    push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    push_exp(2'd2, pf_addr, 1'b0, 64'd0);
`endif
    rf_req = 1'b1; rf_left = 1; pf_req = 1'b1; pf_left = 1;
    run_until_idle(100);

    // Continuous RF pressure against a pending PF.
    rf_addr = 32'h0000_0100; pf_addr = 32'h0000_0200;
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      push_exp(2'd2, pf_addr, 1'b0, 64'd0);
      push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    end
    rf_left = 3; pf_left = 3;
`else
    for (int i = 0; i < 15; i++) push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    push_exp(2'd2, pf_addr, 1'b0, 64'd0);
    push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    rf_left = 17; pf_left = 1;
`endif
    rf_req = 1'b1; pf_req = 1'b1;
    run_until_idle(400);

    // Stray ack while idle must change nothing.
    saved_rsp = rsp_data;
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    step();
    step();
    check_eq("stray_ack_busy", 64'(busy), 64'd0);
    check_eq("stray_ack_rsp", rsp_data, saved_rsp);

    // Reset in the middle of ISSUE drops the transaction.
    lat = 100;
    rf_addr = 32'h0000_0300;
    push_exp(2'd1, rf_addr, 1'b0, 64'd0);
    rf_req = 1'b1; rf_left = 1;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    check_eq("pre_rst_mem_req", 64'(mem_req), 64'd1);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    check_eq("rst_mid_done", 64'({wb_done, rf_done, pf_done}), 64'd0);
    sb_q.delete();
    rf_req = 1'b0; rf_left = 0;
    repeat (3) step();
    rst_n = 1'b1;
    lat = 1;
    repeat (3) step();
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    check_eq("post_rst_mem_req", 64'(mem_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
